// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor types and constants
package proc_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mau_state_t;

  localparam int OPCODE_MSB     = 15;
  localparam int OPCODE_LSB     = 12;
  localparam int DEFAULT_DATA_W = 16;
endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - loadable down-counter with zero flag for SRAM wait states
module mem_wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             dec,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)
      count <= '0;
    else if (load)
      count <= loadValue;
    else if (dec && count != '0)
      count <= count - WIDTH'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multicycle SRAM access sequencer feeding IR/MDR
// Optional misalignment fault detection: MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import proc_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int DATA_W      = DEFAULT_DATA_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteData,
  output logic              Done,
  output logic              Fault,
  output logic [DATA_W-1:0] Instr,
  output logic [3:0]        Opcode,
  output logic [DATA_W-1:0] MDR,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

  mau_state_t        state;
  logic [DATA_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;
  logic [DATA_W-1:0] irReg;
  logic [DATA_W-1:0] mdrReg;
  logic              writeReg;
  logic              irWriteReg;
  logic              cntZero;
  logic              accept;
  logic [DATA_W-1:0] selAddr;
  logic              misaligned;

  assign accept  = ReqValid && ReqReady;
  assign selAddr = IorD ? ALUOut : PC;

`ifdef MEM_ALIGN_CHECK_EN
  logic faultReg;
  assign misaligned = selAddr[0];
  assign Fault      = (state == DONE) && faultReg;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)
      faultReg <= 1'b0;
    else if (state != ACCESS)
      faultReg <= accept && misaligned;
  end
`else
  assign misaligned = 1'b0;
  assign Fault      = 1'b0;
`endif

  mem_wait_counter #(.WIDTH(CNT_W)) u_waitCounter (
    .CLK       (CLK),
    .Reset     (Reset),
    .load      (accept),
    .loadValue (CNT_W'(WAIT_STATES)),
    .dec       (state == ACCESS),
    .zero      (cntZero)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      addrReg    <= '0;
      wdataReg   <= '0;
      writeReg   <= 1'b0;
      irWriteReg <= 1'b0;
      irReg      <= '0;
      mdrReg     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ReqValid) begin
`ifdef MEM_ALIGN_CHECK_EN
            addrReg  <= selAddr;
`else
            // Without the check, odd addresses are silently rounded down.
            addrReg  <= selAddr & ~DATA_W'(1);
`endif
            wdataReg   <= WriteData;
            writeReg   <= ReqWrite;
            irWriteReg <= IRWrite;
            state      <= misaligned ? DONE : ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (cntZero) begin
            state <= DONE;
            if (!writeReg) begin
              if (irWriteReg)
                irReg  <= mem_rdata;
              else
                mdrReg <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ReqReady  = (state != ACCESS);
  assign Done      = (state == DONE);
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && cntZero && writeReg;
  assign mem_addr  = addrReg;
  assign mem_wdata = wdataReg;
  assign Instr     = irReg;
  assign MDR       = mdrReg;
  assign Opcode    = irReg[OPCODE_MSB:OPCODE_LSB];
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (WAIT_STATES 1 and 0)
module tb_mem_access_unit;
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] mdr;
    logic        fault;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0, ReqValid1 = 1'b0;
  logic        ReqWrite = 1'b0, IorD = 1'b0, IRWrite = 1'b0;
  logic [15:0] PC = '0, ALUOut = '0, WriteData = '0;

  logic        ReqReady0, Done0, Fault0, mem_en0, mem_we0;
  logic [15:0] Instr0, MDR0, mem_addr0, mem_wdata0, mem_rdata0;
  logic [3:0]  Opcode0;
  logic        ReqReady1, Done1, Fault1, mem_en1, mem_we1;
  logic [15:0] Instr1, MDR1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  Opcode1;

  logic [15:0] mem [0:127];
  exp_t        expQ[$], expQ1[$];
  logic [31:0] wrQ[$];
  int          nChecks = 0, nFail = 0;

  always #5 CLK = ~CLK;

  assign mem_rdata0 = mem[mem_addr0[7:1]];
  assign mem_rdata1 = mem[mem_addr1[7:1]];

  mem_access_unit #(.WAIT_STATES(1), .DATA_W(16)) u0 (
    .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady0),
    .ReqWrite(ReqWrite), .IorD(IorD), .IRWrite(IRWrite), .PC(PC), .ALUOut(ALUOut),
    .WriteData(WriteData), .Done(Done0), .Fault(Fault0), .Instr(Instr0), .Opcode(Opcode0),
    .MDR(MDR0), .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  mem_access_unit #(.WAIT_STATES(0), .DATA_W(16)) u1 (
    .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid1), .ReqReady(ReqReady1),
    .ReqWrite(ReqWrite), .IorD(IorD), .IRWrite(IRWrite), .PC(PC), .ALUOut(ALUOut),
    .WriteData(WriteData), .Done(Done1), .Fault(Fault1), .Instr(Instr1), .Opcode(Opcode1),
    .MDR(MDR1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFail++;
    $display("FAIL %s: event not expected or never arrived", name);
  endtask

  // SRAM model: word-addressed array, write-through on the strobe edge
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[7'h08] = 16'h8123;
    mem[7'h10] = 16'h1234;
    mem[7'h18] = 16'h5A5A;
    mem[7'h28] = 16'h9ABC;
    mem[7'h12] = 16'h4C4C;
    forever begin
      @(posedge CLK);
      if (mem_we0) mem[mem_addr0[7:1]] = mem_wdata0;
    end
  end

  always @(negedge CLK) begin : monitor0
    exp_t        e;
    logic [31:0] w;
    logic [15:0] ei;
    if (!Reset) begin
      if (mem_we0) begin
        if (wrQ.size() == 0) failNow("unexpected_strobe");
        else begin
          w = wrQ.pop_front();
          check("strobe_addr", mem_addr0, w[31:16]);
          check("strobe_data", mem_wdata0, w[15:0]);
        end
      end
      if (Done0) begin
        if (expQ.size() == 0) failNow("unexpected_done");
        else begin
          e  = expQ.pop_front();
          ei = e.instr;
          check("instr", Instr0, e.instr);
          check("opcode", Opcode0, ei[15:12]);
          check("mdr", MDR0, e.mdr);
          check("fault", Fault0, e.fault);
        end
      end
    end
  end

  always @(negedge CLK) begin : monitor1
    exp_t e;
    if (!Reset && Done1) begin
      if (expQ1.size() == 0) failNow("unexpected_done_ws0");
      else begin
        e = expQ1.pop_front();
        check("ws0_instr", Instr1, e.instr);
        check("ws0_mdr", MDR1, e.mdr);
        check("ws0_fault", Fault1, e.fault);
      end
    end
  end

  task automatic waitReady();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ReqReady0) return;
    end
    failNow("ready_timeout");
  endtask

  // Issue one request to u0, scramble fields after acceptance, observe until Done
  task automatic doReq(input logic wr, input logic iord, input logic irw,
                       input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] wd,
                       output int n, output int enCnt, output int weAt,
                       output logic [15:0] enAddr);
    waitReady();
    ReqWrite = wr; IorD = iord; IRWrite = irw; PC = pc; ALUOut = alu; WriteData = wd;
    ReqValid = 1'b1;
    @(posedge CLK);
    #1;
    ReqValid = 1'b0;
    ReqWrite = ~wr; IorD = ~iord; IRWrite = ~irw;
    PC = 16'hFFFE; ALUOut = 16'hFFFE; WriteData = 16'h0000;
    n = 0; enCnt = 0; weAt = 0; enAddr = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      n = i;
      if (mem_en0) begin enCnt++; enAddr = mem_addr0; end
      if (mem_we0) weAt = i;
      if (Done0) break;
    end
    if (!Done0) failNow("done_timeout");
  endtask

  initial begin
    int          n, enCnt, weAt, n2;
    logic [15:0] enAddr;

    @(negedge CLK);
    check("rst_ready", ReqReady0, 1'b1);
    check("rst_done", Done0, 1'b0);
    check("rst_fault", Fault0, 1'b0);
    check("rst_en", mem_en0, 1'b0);
    check("rst_we", mem_we0, 1'b0);
    check("rst_instr", Instr0, 16'h0000);
    check("rst_mdr", MDR0, 16'h0000);
    check("rst_addr", mem_addr0, 16'h0000);
    check("rst_wdata", mem_wdata0, 16'h0000);
    @(negedge CLK);
    Reset = 1'b0;

    // Instruction fetch from PC into IR
    expQ.push_back('{instr: 16'h8123, mdr: 16'h0000, fault: 1'b0});
    doReq(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, n, enCnt, weAt, enAddr);
    check("fetch_latency", n, 3);
    check("fetch_en_cycles", enCnt, 2);
    check("fetch_addr", enAddr, 16'h0010);
    check("fetch_no_we", weAt, 0);

    // Store via ALUOut
    wrQ.push_back({16'h0040, 16'hBEEF});
    expQ.push_back('{instr: 16'h8123, mdr: 16'h0000, fault: 1'b0});
    doReq(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0040, 16'hBEEF, n, enCnt, weAt, enAddr);
    check("store_latency", n, 3);
    check("store_we_final_cycle", weAt, 2);
    check("store_mem", mem[7'h20], 16'hBEEF);

    // Loads into MDR, including the word just stored
    expQ.push_back('{instr: 16'h8123, mdr: 16'hBEEF, fault: 1'b0});
    doReq(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, n, enCnt, weAt, enAddr);
    expQ.push_back('{instr: 16'h8123, mdr: 16'h1234, fault: 1'b0});
    doReq(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020, 16'h0000, n, enCnt, weAt, enAddr);
    check("load_addr", enAddr, 16'h0020);

    // Back-to-back: ReqValid held high across Done
    expQ.push_back('{instr: 16'h5A5A, mdr: 16'h1234, fault: 1'b0});
    expQ.push_back('{instr: 16'h5A5A, mdr: 16'h9ABC, fault: 1'b0});
    waitReady();
    ReqWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b1; PC = 16'h0030; ReqValid = 1'b1;
    @(posedge CLK);
    #1;
    IorD = 1'b1; IRWrite = 1'b0; ALUOut = 16'h0050;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      n = i;
      if (Done0) break;
    end
    check("b2b_first_period", n, 3);
    check("b2b_ready_in_done", ReqReady0, 1'b1);
    @(posedge CLK);
    #1;
    ReqValid = 1'b0; PC = 16'hFFFE; ALUOut = 16'hFFFE;
    @(negedge CLK);
    check("b2b_access_next", mem_en0, 1'b1);
    check("b2b_addr", mem_addr0, 16'h0050);
    n2 = 1;
    for (int i = 2; i <= 20; i++) begin
      @(negedge CLK);
      n2 = i;
      if (Done0) break;
    end
    check("b2b_second_period", n2, 3);

    // Reset in the middle of a store
    waitReady();
    ReqWrite = 1'b1; IorD = 1'b1; ALUOut = 16'h0060; WriteData = 16'h7777; ReqValid = 1'b1;
    @(posedge CLK);
    #1;
    ReqValid = 1'b0;
    @(negedge CLK);
    check("midrst_en_before", mem_en0, 1'b1);
    #1;
    Reset = 1'b1;
    #1;
    check("midrst_en", mem_en0, 1'b0);
    check("midrst_we", mem_we0, 1'b0);
    check("midrst_instr", Instr0, 16'h0000);
    check("midrst_opcode", Opcode0, 4'h0);
    check("midrst_mdr", MDR0, 16'h0000);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    check("midrst_ready", ReqReady0, 1'b1);
    check("midrst_no_store", mem[7'h30], 16'h0000);

    // Odd address fetch
`ifdef MEM_ALIGN_CHECK_EN
    expQ.push_back('{instr: 16'h0000, mdr: 16'h0000, fault: 1'b1});
    doReq(1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0000, n, enCnt, weAt, enAddr);
    check("misalign_latency", n, 1);
    check("misalign_no_en", enCnt, 0);
`else
    expQ.push_back('{instr: 16'h8123, mdr: 16'h0000, fault: 1'b0});
    doReq(1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0000, n, enCnt, weAt, enAddr);
    check("odd_latency", n, 3);
    check("odd_rounded_addr", enAddr, 16'h0010);
`endif

    // Zero wait states: read into MDR
    expQ1.push_back('{instr: 16'h0000, mdr: 16'h4C4C, fault: 1'b0});
    @(negedge CLK);
    ReqWrite = 1'b0; IorD = 1'b1; IRWrite = 1'b0; ALUOut = 16'h0024; ReqValid1 = 1'b1;
    @(posedge CLK);
    #1;
    ReqValid1 = 1'b0; ALUOut = 16'hFFFE;
    n = 0; enCnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      n = i;
      if (mem_en1) enCnt++;
      if (Done1) break;
    end
    check("ws0_latency", n, 2);
    check("ws0_en_cycles", enCnt, 1);

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", expQ.size() + expQ1.size() + wrQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
